// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC sequencer for a 1-cycle synchronous imem, with a 2-entry decode buffer and redirect flush.
// Ports: clk/rst (sync, active-high); fetch_en gates new fetches; imem_addr/imem_inst form the memory word port;
// redirect_valid/redirect_pc restart fetch at a new byte PC; if_valid/if_ready/if_inst/if_pc hand the buffer head
// to decode; fetch_fault reports a misaligned redirect when FETCH_ALIGN_CHK_EN is defined, otherwise it is tied 0.
module imem_fetch_ctrl #(
  parameter int AddrSize = 32,
  parameter int Inst_Size = 32,
  parameter logic [AddrSize-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic [AddrSize-1:0]  imem_addr,
  input  logic [Inst_Size-1:0] imem_inst,
  input  logic                 redirect_valid,
  input  logic [AddrSize-1:0]  redirect_pc,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [Inst_Size-1:0] if_inst,
  output logic [AddrSize-1:0]  if_pc,
  output logic                 fetch_fault
);
  logic [AddrSize-1:0]  r_pc, r_inflight_pc, w_redir_pc, w_issue_pc;
  logic                 r_inflight, r_fault, w_misalign, w_pop, w_push, w_issue, w_wr_idx;
  logic [1:0]           r_count;
  logic [2:0]           w_used;
  logic [Inst_Size-1:0] r_inst [2];
  logic [AddrSize-1:0]  r_ipc [2];
`ifdef FETCH_ALIGN_CHK_EN
  assign w_redir_pc  = redirect_pc;
  assign w_misalign  = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = r_fault;
`else
  assign w_redir_pc  = redirect_pc & ~AddrSize'(3);
  assign w_misalign  = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  assign w_issue_pc = redirect_valid ? w_redir_pc : r_pc;
  assign imem_addr  = rst ? {2'b00, RESET_PC[AddrSize-1:2]} : {2'b00, w_issue_pc[AddrSize-1:2]};
  assign if_valid   = (r_count != 2'd0) & ~redirect_valid;
  assign if_inst    = r_inst[0];
  assign if_pc      = r_ipc[0];
  assign w_pop      = if_valid & if_ready;
  assign w_push     = r_inflight & ~redirect_valid;
  // Credit: buffered + outstanding - leaving must stay below 2 so a return always has a free slot.
  assign w_used     = redirect_valid ? 3'd0 : 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue    = fetch_en & ~r_fault & ~w_misalign & (w_used < 3'd2);
  // Head stays at slot 0; a push lands just after whatever remains once the pop has shifted.
  assign w_wr_idx   = (r_count - 2'(w_pop)) == 2'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      r_fault       <= 1'b0;
      r_inst[0]     <= '0;
      r_inst[1]     <= '0;
      r_ipc[0]      <= '0;
      r_ipc[1]      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= w_issue_pc;
      r_pc    <= w_issue ? w_issue_pc + AddrSize'(4) : w_issue_pc;
      r_fault <= r_fault | w_misalign;
      r_count <= redirect_valid ? 2'd0 : r_count + 2'(w_push) - 2'(w_pop);
      if (w_pop) begin
        r_inst[0] <= r_inst[1];
        r_ipc[0]  <= r_ipc[1];
      end
      if (w_push) begin
        r_inst[w_wr_idx] <= imem_inst;
        r_ipc[w_wr_idx]  <= r_inflight_pc;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed plus random stimulus against a queue-based fetch model.
module tb_imem_fetch_ctrl;
  logic        clk = 1'b0, rst, fetch_en, redirect_valid, if_ready, if_valid, fetch_fault;
  logic [31:0] imem_addr, imem_inst, redirect_pc, if_inst, if_pc;
  int          checks = 0, errors = 0;
  logic [31:0] m_pc, m_ipc, o_pc;
  logic [31:0] q[$];
  bit          m_infl, m_fault, o_valid;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.AddrSize(32), .Inst_Size(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] widx);
    return (widx * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  always @(posedge clk) imem_inst <= mem_f(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    m_pc = 32'h0; m_ipc = 32'h0; m_infl = 1'b0; m_fault = 1'b0; q.delete();
  endtask

  task automatic cycle(input bit fen, input bit rdy, input bit rv, input logic [31:0] rpc);
    logic [31:0] ipc;
    bit          mv, pop, push, mis, iss;
    int          used;
    @(negedge clk);
    rst = 1'b0; fetch_en = fen; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
`ifdef FETCH_ALIGN_CHK_EN
    mis = rv && (rpc[1:0] != 2'b00);
    ipc = rv ? rpc : m_pc;
`else
    mis = 1'b0;
    ipc = rv ? {rpc[31:2], 2'b00} : m_pc;
`endif
    #1;
    mv = (q.size() > 0) && !rv;
    chk("if_valid", 32'(if_valid), 32'(mv));
    if (mv) begin
      chk("if_pc", if_pc, q[0]);
      chk("if_inst", if_inst, mem_f(q[0] >> 2));
    end
    chk("imem_addr", imem_addr, ipc >> 2);
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    o_valid = if_valid; o_pc = if_pc;
    pop  = mv && rdy;
    push = m_infl && !rv;
    used = rv ? 0 : q.size() + int'(m_infl) - int'(pop);
    iss  = fen && !m_fault && !mis && (used < 2);
    if (rv) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(m_ipc);
    end
    if (iss) m_ipc = ipc;
    m_infl  = iss;
    m_pc    = iss ? ipc + 32'd4 : ipc;
    m_fault = m_fault | mis;
  endtask

  initial begin
    logic [31:0] a0;
    bit          ov[8];
    logic [31:0] op[8];
    rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 0);
      ov[i] = o_valid; op[i] = o_pc;
    end
    chk("lat_c0", 32'(ov[0]), 32'd0);
    chk("lat_c1", 32'(ov[1]), 32'd0);
    chk("lat_c2", 32'(ov[2]), 32'd1);
    for (int i = 2; i < 6; i++) chk("seq_pc", op[i], 32'((i - 2) * 4));
    cycle(1, 0, 0, 0);
    a0 = imem_addr;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      chk("stall_addr", imem_addr, a0);
    end
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h40);
    ov[0] = o_valid;
    for (int i = 1; i < 5; i++) begin
      cycle(1, 1, 0, 0);
      ov[i] = o_valid; op[i] = o_pc;
    end
    chk("redir_r0", 32'(ov[0]), 32'd0);
    chk("redir_r1", 32'(ov[1]), 32'd0);
    chk("redir_v2", 32'(ov[2]), 32'd1);
    chk("redir_p2", op[2], 32'h40);
    chk("redir_p3", op[3], 32'h44);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'hFFFF_FFF0);
    for (int i = 0; i < 7; i++) begin
      cycle(1, 1, 0, 0);
      op[i] = o_pc;
    end
    chk("wrap_fc", op[4], 32'hFFFF_FFFC);
    chk("wrap_00", op[5], 32'h0);
    cycle(1, 1, 1, 32'h42);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0);
      ov[i] = o_valid; op[i] = o_pc;
    end
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_halt", 32'(ov[3]), 32'd0);
    do_reset();
`else
    chk("mis_pc", op[1], 32'h40);
    chk("mis_pc1", op[2], 32'h44);
`endif
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_FFFC));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
